mem_ctrl: RTL and testbench

Sequential memory controller that shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage. It takes 32-bit fetch and 1/2/4-byte load/store requests, splits them into consecutive byte accesses, assembles little-endian results and signals completion. It sits between the IF/MEM stages and the RAM, and drives the pipeline stall lines while a transfer is outstanding.

---
 rtl/mem_ctrl_pkg.sv | 42 ++++
 rtl/mem_ctrl_ifbuf.sv | 47 ++++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types, widths and length codes for the byte-serial
//               memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  localparam int RamAddrBus = 17;
  localparam int RamDataBus = 8;

  // mem_len encodings; the unused code 3 behaves like a word
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Byte count of a transfer for a given length code
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_ifbuf.sv
// ============================================================================
// Module      : mem_ctrl_ifbuf
// Description : Single-entry fetch buffer (tag, word, valid) with hit compare.
//               Only instantiated when MEM_CTRL_IF_BUFFER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl_ifbuf
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill,
  input  logic                  inval,
  input  logic [RamAddrBus-1:0] fill_tag,
  input  logic [31:0]           fill_data,
  input  logic [RamAddrBus-1:0] lookup_tag,
  output logic                  hit,
  output logic [31:0]           hit_data
);

  logic                  r_valid;
  logic [RamAddrBus-1:0] r_tag;
  logic [31:0]           r_data;

  // Entry update: a store invalidates, a completed fetch refills
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (inval) begin
      r_valid <= 1'b0;
    end else if (fill) begin
      r_valid <= 1'b1;
      r_tag   <= fill_tag;
      r_data  <= fill_data;
    end
  end

  assign hit      = r_valid && (r_tag == lookup_tag);
  assign hit_data = r_data;

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Shares one byte-wide RAM port between instruction fetch and
//               the MEM stage. Splits 1/2/4-byte requests into consecutive
//               byte accesses and assembles little-endian results.
//               Optional fetch buffer: define MEM_CTRL_IF_BUFFER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  if_stall,
  output logic                  mem_stall,
  output logic                  ram_we,
  output logic [RamAddrBus-1:0] ram_addr,
  output logic [RamDataBus-1:0] ram_dout,
  input  logic [RamDataBus-1:0] ram_din
);

  state_t                r_state;
  owner_t                r_owner;
  logic [2:0]            r_idx;
  logic [2:0]            r_len;
  logic [RamAddrBus-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic                  r_if_done;
  logic                  r_mem_done;

  logic [RamAddrBus-1:0] w_cur_addr;
  logic                  w_rd_drive;
  logic [1:0]            w_cap_idx;
  logic [31:0]           w_buf_next;
  logic                  w_hit;
  logic [31:0]           w_hit_data;
  logic                  w_unused_addr;

  // Address arithmetic is 17-bit so it wraps naturally at the top of RAM
  assign w_cur_addr = r_base + {{(RamAddrBus-3){1'b0}}, r_idx};
  // The final RD cycle only captures; no address is presented then
  assign w_rd_drive = (r_state == ST_RD) && (r_idx != r_len);
  // Data on ram_din belongs to the address presented one cycle earlier
  assign w_cap_idx  = r_idx[1:0] - 2'd1;

  // Merge the incoming RAM byte into its little-endian lane
  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{w_cap_idx, 3'b000} +: 8] = ram_din;
  end

  assign ram_we   = (r_state == ST_WR);
  assign ram_addr = (w_rd_drive || r_state == ST_WR) ? w_cur_addr : '0;
  assign ram_dout = (r_state == ST_WR) ? r_wdata[{r_idx[1:0], 3'b000} +: 8] : '0;

  assign if_done   = r_if_done;
  assign mem_done  = r_mem_done;
  assign if_rdata  = r_buf;
  assign mem_rdata = r_buf;
  assign if_stall  = if_req && !r_if_done;
  assign mem_stall = mem_req && !r_mem_done;

  assign w_unused_addr = ^{if_addr[31:RamAddrBus], mem_addr[31:RamAddrBus]};

`ifdef MEM_CTRL_IF_BUFFER_EN
  logic w_fill;
  logic w_inval;

  assign w_fill  = (r_state == ST_RD) && (r_idx == r_len) && (r_owner == OWN_IF);
  assign w_inval = (r_state == ST_IDLE) && mem_req && mem_we;

  mem_ctrl_ifbuf u_ifbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (w_fill),
    .inval      (w_inval),
    .fill_tag   (r_base),
    .fill_data  (w_buf_next),
    .lookup_tag (if_addr[RamAddrBus-1:0]),
    .hit        (w_hit),
    .hit_data   (w_hit_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  // Transfer sequencer: accept, walk the bytes, pulse the owner's done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_IF;
      r_idx      <= '0;
      r_len      <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (mem_req) begin
            r_owner <= OWN_MEM;
            r_base  <= mem_addr[RamAddrBus-1:0];
            r_len   <= len_to_n(mem_len);
            r_wdata <= mem_wdata;
            r_buf   <= '0;
            r_state <= mem_we ? ST_WR : ST_RD;
          end else if (if_req) begin
            r_owner <= OWN_IF;
            r_base  <= if_addr[RamAddrBus-1:0];
            r_len   <= 3'd4;
            r_wdata <= '0;
            if (w_hit) begin
              r_buf     <= w_hit_data;
              r_if_done <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_buf   <= '0;
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_idx != 3'd0) begin
            r_buf <= w_buf_next;
          end
          if (r_idx == r_len) begin
            r_if_done  <= (r_owner == OWN_IF);
            r_mem_done <= (r_owner == OWN_MEM);
            r_state    <= ST_RESP;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_WR: begin
          if (r_idx == r_len - 3'd1) begin
            r_if_done  <= (r_owner == OWN_IF);
            r_mem_done <= (r_owner == OWN_MEM);
            r_state    <= ST_RESP;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte RAM
//               model, a shadow memory and a completion scoreboard.
//               Honours MEM_CTRL_IF_BUFFER_EN for the fetch-buffer cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        if_stall;
  logic        mem_stall;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  logic [7:0] ram    [0:131071];
  logic [7:0] shadow [0:131071];

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .if_stall  (if_stall),
    .mem_stall (mem_stall),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle c spans posedge c .. posedge c+1
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (if_done || mem_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL unexpected_done: observed if=%0b mem=%0b expected none", if_done, mem_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_owner", {30'd0, if_done, mem_done}, {30'd0, !e.is_mem, e.is_mem});
        chk("done_cycle", cyc, e.cyc);
        if (e.chk_data) chk("rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
      end
    end
  end

  // One complete transfer with per-cycle RAM-port and stall checks
  task automatic xfer(input bit is_mem, input bit we, input logic [1:0] len,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit hit);
    int          n;
    int          dur;
    logic [31:0] exp;
    logic [16:0] a;
    logic [16:0] ai;
    exp_t        e;
    n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    dur = hit ? 1 : (we ? n + 1 : n + 2);
    a   = addr[16:0];
    exp = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 17'(i);
      if (we) shadow[ai] = wdata[8*i +: 8];
      else    exp[8*i +: 8] = shadow[ai];
    end
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    e.is_mem = is_mem; e.chk_data = !we; e.data = exp; e.cyc = cyc + dur;
    sb.push_back(e);
    for (int k = 0; k <= dur; k++) begin
      bit act;
      @(negedge clk);
      act = !hit && (k >= 1) && (k <= n);
      ai  = a + 17'(k - 1);
      chk("stall", {31'd0, is_mem ? mem_stall : if_stall}, {31'd0, k < dur});
      chk("ram_we", {31'd0, ram_we}, {31'd0, act && we});
      chk("ram_addr", {15'd0, ram_addr}, act ? {15'd0, ai} : 32'd0);
      chk("ram_dout", {24'd0, ram_dout}, (act && we) ? {24'd0, wdata[8*(k-1) +: 8]} : 32'd0);
      @(posedge clk); #1;
    end
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 131072; i++) begin ram[i] = 8'h00; shadow[i] = 8'h00; end
    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    ram[17'h200] = 8'hA1; ram[17'h201] = 8'hB2; ram[17'h202] = 8'hC3; ram[17'h203] = 8'hD4;
    ram[17'h400] = 8'h77; ram[17'h403] = 8'h88; ram[17'h000] = 8'h5A;
    for (int i = 0; i < 131072; i++) shadow[i] = ram[i];

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_ram", {14'd0, ram_we, ram_addr}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_stall", {30'd0, if_stall, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word fetch, then the same fetch again (buffer hit when enabled)
    xfer(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 1'b0);
`ifdef MEM_CTRL_IF_BUFFER_EN
    xfer(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 1'b1);
`else
    xfer(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 1'b0);
`endif
    // Byte store at the top address, then a wrapping half load
    xfer(1'b1, 1'b1, 2'd0, 32'h0001_FFFF, 32'h0000_00AB, 1'b0);
    xfer(1'b1, 1'b0, 2'd1, 32'h0001_FFFF, 32'd0, 1'b0);
    chk("wrap_half_shadow", {shadow[17'h00000], shadow[17'h1FFFF]}, 32'h5AAB);
    // Fetch after a store always takes the full path
    xfer(1'b0, 1'b0, 2'd2, 32'h100, 32'd0, 1'b0);
    // Word store + load back, upper address bits ignored
    xfer(1'b1, 1'b1, 2'd2, 32'hFFFE_0300, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'd0, 1'b0);

    // Simultaneous requests: MEM first, IF in the IDLE cycle after mem_done
    begin
      int          t0;
      exp_t        e;
      logic [31:0] exp_addr;
      if_req = 1'b1; if_addr = 32'h100;
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h200;
      t0 = cyc;
      e.is_mem = 1'b1; e.chk_data = 1'b1; e.data = 32'hD4C3_B2A1; e.cyc = t0 + 6;
      sb.push_back(e);
      e.is_mem = 1'b0; e.chk_data = 1'b1; e.data = 32'h4433_2211; e.cyc = t0 + 13;
      sb.push_back(e);
      for (int k = 0; k <= 13; k++) begin
        @(negedge clk);
        exp_addr = (k >= 1 && k <= 4) ? 32'h200 + 32'(k - 1) :
                   (k >= 8 && k <= 11) ? 32'h100 + 32'(k - 8) : 32'd0;
        chk("both_if_stall", {31'd0, if_stall}, {31'd0, k < 13});
        chk("both_mem_stall", {31'd0, mem_stall}, {31'd0, k < 6});
        chk("both_ram_addr", {15'd0, ram_addr}, exp_addr);
        @(posedge clk); #1;
        if (k == 6) mem_req = 1'b0;
      end
      if_req = 1'b0;
    end

    // Unaligned half store, word load across it, length code 3 as word
    xfer(1'b1, 1'b1, 2'd1, 32'h401, 32'h0000_1234, 1'b0);
    xfer(1'b1, 1'b0, 2'd2, 32'h400, 32'd0, 1'b0);
    chk("unaligned_shadow", {shadow[17'h403], shadow[17'h402], shadow[17'h401], shadow[17'h400]}, 32'h8812_3477);
    xfer(1'b1, 1'b0, 2'd3, 32'h400, 32'd0, 1'b0);

    // Reset in cycle T+2 of a word store: two bytes land, no done pulse
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = 32'h4433_2211;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_we1", {15'd0, ram_we, ram_addr[15:0]}, {15'd0, 1'b1, 16'h0500});
    chk("rst_mid_dout1", {24'd0, ram_dout}, 32'h11);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_addr2", {15'd0, ram_addr}, 32'h501);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_outs", {14'd0, ram_we, ram_addr}, 32'd0);
    chk("rst_mid_done", {28'd0, if_done, mem_done, if_stall, mem_stall}, 32'd0);
    chk("rst_mid_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_ram", {ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]}, 32'h0000_2211);
    shadow[17'h500] = 8'h11; shadow[17'h501] = 8'h22;
    chk("rst_mid_sb", sb.size(), 32'd0);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 2'd2, 32'h500, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
